// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Bundle of EX/MEM request, data-memory port and MEM/WB result
//                signals around the memory-stage load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Pipeline request side
    logic              memRead;
    logic              memWrite;
    logic [1:0]        memSize;
    logic              memUnsigned;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] storeData;

    // Data memory side
    logic [DATA_W-1:0] dmemReadData;
    logic [ADDR_W-1:0] dmemAddress;
    logic              dmemWrite;
    logic [DATA_W-1:0] dmemWriteData;

    // Results back to the pipeline
    logic [DATA_W-1:0] loadData;
    logic              stall;
    logic              addrError;

    // Environment view: pipeline plus data memory
    modport master (
        output memRead, memWrite, memSize, memUnsigned, address, storeData,
        output dmemReadData,
        input  dmemAddress, dmemWrite, dmemWriteData,
        input  loadData, stall, addrError
    );

    // Load/store unit view
    modport slave (
        input  memRead, memWrite, memSize, memUnsigned, address, storeData,
        input  dmemReadData,
        output dmemAddress, dmemWrite, dmemWriteData,
        output loadData, stall, addrError
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory-stage load/store unit. Turns byte/half/word accesses
//                into word accesses on a word-addressed data memory, using a
//                two-cycle read-modify-write for sub-word stores, and extracts
//                and extends load data. Flags misaligned accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_RMW_WRITE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_word;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_addr_error;

    logic [ADDR_W-1:0]   w_aligned_addr;
    logic                w_is_byte;
    logic                w_is_half;
    logic                w_is_word;
    logic                w_misaligned;
    logic                w_store_ok;
    logic                w_load_ok;
    logic                w_latch;
    logic [4:0]          w_byte_shift;
    logic [4:0]          w_half_shift;
    logic [7:0]          w_lane_byte;
    logic [15:0]         w_lane_half;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_load_ext;

    // Address/size decode; size 11 is reserved and behaves as a word access
    assign w_aligned_addr = {bus.address[ADDR_W-1:2], 2'b00};
    assign w_is_byte      = (bus.memSize == c_SIZE_BYTE);
    assign w_is_half      = (bus.memSize == c_SIZE_HALF);
    assign w_is_word      = bus.memSize[1];
    assign w_misaligned   = (w_is_half && bus.address[0]) ||
                            (w_is_word && (bus.address[1:0] != 2'b00));
    assign w_store_ok     = bus.memWrite && !w_misaligned;
    assign w_load_ok      = bus.memRead  && !w_misaligned;
    assign w_byte_shift   = {bus.address[1:0], 3'b000};
    assign w_half_shift   = {bus.address[1], 4'b0000};
    assign w_lane_byte    = bus.dmemReadData[w_byte_shift +: 8];
    assign w_lane_half    = bus.dmemReadData[w_half_shift +: 16];

    // Merge the low store bits into the current memory word at the addressed lane(s)
    always_comb begin
        w_merged = bus.dmemReadData;
        if (w_is_byte) begin
            w_merged[w_byte_shift +: 8] = bus.storeData[7:0];
        end else begin
            w_merged[w_half_shift +: 16] = bus.storeData[15:0];
        end
    end

    // Select and sign/zero-extend the load lane
    always_comb begin
        w_load_ext = bus.dmemReadData;
        if (w_is_byte) begin
            w_load_ext = {{(DATA_W-8){w_lane_byte[7] & ~bus.memUnsigned}}, w_lane_byte};
        end else if (w_is_half) begin
            w_load_ext = {{(DATA_W-16){w_lane_half[15] & ~bus.memUnsigned}}, w_lane_half};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and memory/pipeline outputs; reset forces every output low
    always_comb begin
        w_next_state      = r_state;
        w_latch           = 1'b0;
        bus.dmemAddress   = w_aligned_addr;
        bus.dmemWrite     = 1'b0;
        bus.dmemWriteData = '0;
        bus.loadData      = '0;
        bus.stall         = 1'b0;
        if (reset) begin
            w_next_state    = S_IDLE;
            bus.dmemAddress = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_store_ok) begin
                        if (w_is_word) begin
                            bus.dmemWrite     = 1'b1;
                            bus.dmemWriteData = bus.storeData;
                        end else begin
                            bus.stall    = 1'b1;
                            w_latch      = 1'b1;
                            w_next_state = S_RMW_WRITE;
                        end
                    end
                    if (w_load_ok) begin
                        bus.loadData = w_load_ext;
                    end
                end
                S_RMW_WRITE: begin
                    bus.dmemAddress   = r_addr;
                    bus.dmemWrite     = 1'b1;
                    bus.dmemWriteData = r_word;
                    w_next_state      = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Capture the merged word and its address for the write-back cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= '0;
            r_addr <= '0;
        end else if (w_latch) begin
            r_word <= w_merged;
            r_addr <= w_aligned_addr;
        end
    end

    // Misalignment flag, registered from whatever access is presented in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_error <= 1'b0;
        end else begin
            r_addr_error <= (r_state == S_IDLE) &&
                            (bus.memRead || bus.memWrite) && w_misaligned;
        end
    end

    assign bus.addrError = r_addr_error & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. A byte-array model
//                of memory predicts every load, store and flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    logic clk = 1'b0;
    logic reset;

    mem_access_unit_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    mem_access_unit #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: 64 words, negedge write, combinational read
    logic [31:0] dmem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    always @(negedge clk) begin
        if (pre_we) begin
            dmem[pre_idx] <= pre_val;
        end else if (bus.dmemWrite) begin
            dmem[bus.dmemAddress[7:2]] <= bus.dmemWriteData;
        end
    end

    assign bus.dmemReadData = dmem[bus.dmemAddress[7:2]];

    // Reference model: byte-addressed memory image
    logic [7:0] model_mem [0:255];
    logic       exp_err;
    int         total = 0;
    int         bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {model_mem[b + 8'd3], model_mem[b + 8'd2], model_mem[b + 8'd1], model_mem[b]};
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            model_mem[a + 8'(k)] = v[8*k +: 8];
        end
    endtask

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [31:0] v;
        b = a[7:0];
        v = 32'd0;
        for (int k = 0; k < size_bytes(sz); k++) begin
            v[8*k +: 8] = model_mem[b + 8'(k)];
        end
        if (!uns && sz == 2'd0 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (!uns && sz == 2'd1 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        bus.memRead     = rd;
        bus.memWrite    = wr;
        bus.memSize     = sz;
        bus.memUnsigned = uns;
        bus.address     = a;
        bus.storeData   = d;
    endtask

    // One pipeline operation, including its write-back cycle when it is a sub-word store
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        logic        mis;
        logic        st;
        int          n;
        logic [31:0] exp_load;
        @(posedge clk);
        #1;
        drive(rd, wr, sz, uns, a, d);
        mis      = is_misaligned(sz, a);
        n        = size_bytes(sz);
        st       = wr && !mis;
        exp_load = (rd && !mis) ? model_load(a, sz, uns) : 32'd0;
        #2;
        check_val("addrError", 32'(bus.addrError), 32'(exp_err));
        check_val("stall",     32'(bus.stall), 32'(st && n < 4));
        check_val("dmemWrite", 32'(bus.dmemWrite), 32'(st && n == 4));
        check_val("loadData",  bus.loadData, exp_load);
        check_val("dmemAddress", bus.dmemAddress, {a[31:2], 2'b00});
        if (st) begin
            for (int k = 0; k < n; k++) begin
                model_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
            end
        end
        if (st && n == 4) begin
            check_val("wordWriteData", bus.dmemWriteData, d);
        end
        exp_err = (rd || wr) && mis;
        if (st && n < 4) begin
            @(posedge clk);
            #1;
            drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), 1'($urandom),
                  $urandom, $urandom);
            #2;
            check_val("rmw_addrError", 32'(bus.addrError), 32'(exp_err));
            check_val("rmw_stall",     32'(bus.stall), 32'd0);
            check_val("rmw_dmemWrite", 32'(bus.dmemWrite), 32'd1);
            check_val("rmw_writeData", bus.dmemWriteData, model_word(a[7:0]));
            check_val("rmw_address",   bus.dmemAddress, {a[31:2], 2'b00});
            check_val("rmw_loadData",  bus.loadData, 32'd0);
            exp_err = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        pre_we  = 1'b0;
        pre_idx = '0;
        pre_val = '0;
        exp_err = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'($urandom);
        end
        set_word(8'h10, 32'h0000_0000);
        set_word(8'h20, 32'h1122_3344);
        set_word(8'h30, 32'h0000_0000);

        // Preload memory under reset while checking that reset silences every output
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            pre_we  = 1'b1;
            pre_idx = 6'(i);
            pre_val = model_word(8'(4 * i));
            drive(1'b1, 1'b1, 2'($urandom), 1'($urandom), $urandom | 32'h1, $urandom);
            #2;
            if (i < 3) begin
                check_val("reset_dmemWrite", 32'(bus.dmemWrite), 32'd0);
                check_val("reset_stall",     32'(bus.stall), 32'd0);
                check_val("reset_loadData",  bus.loadData, 32'd0);
                check_val("reset_dmemAddress", bus.dmemAddress, 32'd0);
                check_val("reset_writeData", bus.dmemWriteData, 32'd0);
                check_val("reset_addrError", 32'(bus.addrError), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        // Word store then load
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
        // Byte store via read-modify-write, then unsigned and signed loads
        do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_00AB);
        do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'd0);
        do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'd0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0);
        // Half store and loads
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0032, 32'h0000_8001);
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0032, 32'd0);
        do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0032, 32'd0);
        // Misaligned word store and half load
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0013, 32'h1234_5678);
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0031, 32'd0);
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0044, 32'd0);

        // Reset during the write-back cycle of a byte store
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0040, 32'h0000_005A);
        #2;
        check_val("rst_rmw_stall1", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_val("rst_rmw_dmemWrite", 32'(bus.dmemWrite), 32'd0);
        check_val("rst_rmw_stall",     32'(bus.stall), 32'd0);
        check_val("rst_rmw_address",   bus.dmemAddress, 32'd0);
        check_val("rst_rmw_writeData", bus.dmemWriteData, 32'd0);
        check_val("rst_rmw_loadData",  bus.loadData, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0);

        // Back-to-back byte stores into neighbouring lanes
        do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0050, 32'h0000_0001);
        do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0051, 32'h0000_0002);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0050, 32'd0);

        // Random mix of loads, stores, combined requests and idle cycles
        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  {24'($urandom), 8'($urandom)}, $urandom);
        end
        do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        // Final memory image against the model
        @(posedge clk);
        #3;
        for (int i = 0; i < 64; i++) begin
            check_val($sformatf("mem[%02h]", 4 * i), dmem[i], model_word(8'(4 * i)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit sitting directly upstream of the word-addressed data memory.
- Takes EX/MEM control, address and store data, and converts byte/halfword/word accesses into word reads and word writes.
- Sub-word stores use a two-cycle read-modify-write with a pipeline stall.
- Extracts and sign/zero-extends load data from the memory's word read port, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; fixed at 32, byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  clock; memory writes on negedge, this unit's registers on posedge
- reset  in  1  reset, synchronous, active-high
- memRead  in  1  load request from EX/MEM
- memWrite  in  1  store request from EX/MEM
- memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- memUnsigned  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
- address  in  ADDR_W  byte address
- storeData  in  DATA_W  rt value; low byte/half used for sb/sh
- dmemReadData  in  DATA_W  combinational read word from data memory
- dmemAddress  out  ADDR_W  word-aligned address to data memory
- dmemWrite  out  1  write enable to data memory
- dmemWriteData  out  DATA_W  full word to write
- loadData  out  DATA_W  extended load result to MEM/WB
- stall  out  1  holds PC/IF/ID/EX/MEM registers
- addrError  out  1  registered misalignment flag, one-cycle pulse

Behaviour:
- Lanes are little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
- Aligned address = {address[31:2],2'b00}.
- Misaligned: half with address[0]=1; word with address[1:0]!=0. A misaligned store is suppressed (no dmemWrite, no stall). A misaligned load returns 0.
- addrError is registered from the access that is present in IDLE, so it is high in the cycle after that access.
- FSM states: IDLE, RMW_WRITE.
- IDLE, word store (aligned): dmemAddress = aligned address, dmemWriteData = storeData, dmemWrite=1, stall=0. Single cycle.
- IDLE, byte/half store (aligned):
  - dmemWrite=0, stall=1.
  - Merge storeData low bits into dmemReadData at the selected lane(s).
  - Latch merged word and aligned address on posedge, then go to RMW_WRITE.
- RMW_WRITE:
  - dmemAddress = latched address, dmemWriteData = latched word, dmemWrite=1, stall=0. Live inputs are ignored.
  - Return to IDLE unconditionally.
- Loads: 0 extra latency; loadData is combinational from dmemReadData, lane selected by address[1:0], extended per memUnsigned. Valid only in IDLE; loadData=0 in RMW_WRITE.
- memRead and memWrite both high: the store takes precedence; loadData is still driven from the read word.
- Neither request high: dmemWrite=0, stall=0, loadData=0, dmemAddress = aligned address.
- Reset (any state, including mid-RMW): state IDLE, latched word/address 0, addrError 0, no write issued. In the reset cycle all outputs are 0 (dmemWrite=0, stall=0, loadData=0, dmemAddress=0, dmemWriteData=0).
- stall is never high for two consecutive cycles. A store followed back-to-back by another store produces stall patterns 1,0,1,0.

Test Plan:
- Word store then load: mem[0x10] initialised to 0. Issue sw 0xDEADBEEF @0x10, then lw @0x10. sw: dmemWrite=1 in the same cycle, stall never asserted. lw: loadData=0xDEADBEEF.
- Byte store RMW: mem[0x20]=0x11223344, sb 0xAB @0x21 -> stall=1 for one cycle, then dmemWrite=1 with 0x1122AB44; following lbu @0x21=0x000000AB, lb @0x21=0xFFFFFFAB.
- Half store/load: mem[0x30]=0, sh 0x8001 @0x32 -> writes 0x80010000; lh @0x32=0xFFFF8001, lhu=0x00008001.
- Misaligned: sw @0x13 and lh @0x31 -> no dmemWrite, loadData=0, addrError=1 exactly one cycle later, stall=0.
- Reset mid-RMW: sb @0x40, assert reset in the RMW_WRITE cycle -> dmemWrite=0, mem[0x40] unchanged, stall=0, state IDLE next cycle.
- Back-to-back sb @0x50 lane0 = 0x01, then sb @0x51 lane1 = 0x02 -> stall sequence 1,0,1,0; final word 0xXXXX0201 with upper bytes preserved.
